pm_min_selector: RTL and testbench

- Path-metric selector for the add-compare-select / traceback stage of the Viterbi decoder.
- Compares four unsigned path metrics and reports the 2-bit index of the smallest as d1:d0, plus the minimum value itself.
- Result is registered: one clock of latency, with a valid flag.

---
 rtl/pm_min_selector_if.sv | 25 ++
 rtl/pm_min_selector.sv | 72 +++++++
 tb/tb_pm_min_selector.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pm_min_selector_if.sv
// Bundle of the path-metric selector's input metrics and registered result.
// Valid-only handshake: in_valid qualifies pm0..pm3 for one cycle; out_valid marks one result, no ready/backpressure.
interface pm_min_selector_if #(
   parameter int PM_WIDTH = 4
);
   logic                in_valid;
   logic [PM_WIDTH-1:0] pm0;
   logic [PM_WIDTH-1:0] pm1;
   logic [PM_WIDTH-1:0] pm2;
   logic [PM_WIDTH-1:0] pm3;
   logic                d0;
   logic                d1;
   logic [PM_WIDTH-1:0] min_pm;
   logic                out_valid;

   modport master (
      output in_valid, pm0, pm1, pm2, pm3,
      input  d0, d1, min_pm, out_valid
   );

   modport slave (
      input  in_valid, pm0, pm1, pm2, pm3,
      output d0, d1, min_pm, out_valid
   );
endinterface

// File: rtl/pm_min_selector.sv
// Picks the smallest of four unsigned path metrics (lowest index wins ties)
// and registers its 2-bit index and value with one cycle of latency.
module pm_min_selector #(
   parameter int PM_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pm_min_selector_if.slave      bus
);

   logic                sel_a;
   logic [PM_WIDTH-1:0] win_a;
   logic                sel_b;
   logic [PM_WIDTH-1:0] win_b;
   logic                sel_top;

   logic [1:0]          idx_d,       idx_q;
   logic [PM_WIDTH-1:0] min_pm_d,    min_pm_q;
   logic                out_valid_d, out_valid_q;

   // Strict less-than at every node keeps the lower index on ties.
   always_comb begin
      sel_a = 1'b0;
      win_a = bus.pm0;
      if (bus.pm1 < bus.pm0) begin
         sel_a = 1'b1;
         win_a = bus.pm1;
      end

      sel_b = 1'b0;
      win_b = bus.pm2;
      if (bus.pm3 < bus.pm2) begin
         sel_b = 1'b1;
         win_b = bus.pm3;
      end

      sel_top = (win_b < win_a);
   end

   always_comb begin
      idx_d       = idx_q;
      min_pm_d    = min_pm_q;
      out_valid_d = bus.in_valid;
      if (bus.in_valid) begin
         if (sel_top) begin
            idx_d    = {1'b1, sel_b};
            min_pm_d = win_b;
         end else begin
            idx_d    = {1'b0, sel_a};
            min_pm_d = win_a;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         min_pm_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         min_pm_q    <= min_pm_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.d0        = idx_q[0];
   assign bus.d1        = idx_q[1];
   assign bus.min_pm    = min_pm_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_pm_min_selector.sv
// Randomized and directed bench for pm_min_selector with a queue-based scoreboard
// and a reference that scans the four metrics for the first minimum.
module tb_pm_min_selector;

   localparam int W = 4;

   logic clk;
   logic rst_n;

   pm_min_selector_if #(.PM_WIDTH(W)) bus_if ();

   pm_min_selector #(.PM_WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [W+1:0] exp_q[$];
   int           due_q[$];
   logic [W+1:0] held;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [W+1:0] ref_min(input logic [W-1:0] a, b, c, d);
      logic [W-1:0] m[4];
      int best;
      m[0] = a; m[1] = b; m[2] = c; m[3] = d;
      best = 0;
      for (int i = 1; i < 4; i++)
         if (m[i] < m[best]) best = i;
      return {best[1:0], m[best]};
   endfunction

   task automatic check(input string name, input logic [W+2:0] act, input logic [W+2:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [W-1:0] a, b, c, d, input logic v);
      @(posedge clk);
      #1;
      bus_if.in_valid = v;
      bus_if.pm0 = a;
      bus_if.pm1 = b;
      bus_if.pm2 = c;
      bus_if.pm3 = d;
      if (v) begin
         exp_q.push_back(ref_min(a, b, c, d));
         due_q.push_back(cyc + 1);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         send(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
              W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), 1'b0);
   endtask

   function automatic logic [W-1:0] pick_pm();
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) return '0;
      if (r == 1) return '1;
      return W'($urandom_range(0, (1 << W) - 1));
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [W+1:0] e;
      int due;
      if (!rst_n) begin
         check("reset_outputs", {bus_if.out_valid, bus_if.d1, bus_if.d0, bus_if.min_pm}, '0);
         held = '0;
      end else if (bus_if.out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", {1'b1, bus_if.d1, bus_if.d0, bus_if.min_pm}, '0);
         end else begin
            e   = exp_q.pop_front();
            due = due_q.pop_front();
            check("result", {1'b1, bus_if.d1, bus_if.d0, bus_if.min_pm}, {1'b1, e});
            check("latency", (W+3)'(cyc), (W+3)'(due));
            held = e;
         end
      end else begin
         if (due_q.size() != 0 && due_q[0] <= cyc)
            check("missing_valid", {1'b0, bus_if.d1, bus_if.d0, bus_if.min_pm}, {1'b1, exp_q[0]});
         check("hold", {1'b0, bus_if.d1, bus_if.d0, bus_if.min_pm}, {1'b0, held});
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      held = '0;
      rst_n = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.pm0 = 4'd9; bus_if.pm1 = 4'd2; bus_if.pm2 = 4'd13; bus_if.pm3 = 4'd6;

      // Asynchronous reset before any clock edge, with garbage inputs applied.
      #2 rst_n = 1'b0;
      #1 check("async_reset", {bus_if.out_valid, bus_if.d1, bus_if.d0, bus_if.min_pm}, '0);
      bus_if.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(3);

      send(1, 3, 5, 15, 1'b1);
      send(15, 1, 3, 5, 1'b1);
      send(5, 15, 1, 3, 1'b1);
      send(3, 5, 15, 1, 1'b1);
      send(7, 7, 7, 7, 1'b1);
      send(9, 2, 9, 2, 1'b1);
      send(4, 6, 0, 0, 1'b1);
      send(15, 15, 15, 15, 1'b1);
      send(15, 15, 15, 0, 1'b1);
      send(0, 0, 0, 0, 1'b1);
      idle(1);

      // Hold: invalid inputs that would win must not disturb the last result.
      send(1, 3, 5, 15, 1'b1);
      send(15, 15, 15, 0, 1'b0);
      idle(2);

      // Reset mid-stream, asserted after the result has been observed.
      send(3, 5, 15, 1, 1'b1);
      send(0, 0, 0, 0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("mid_reset", {bus_if.out_valid, bus_if.d1, bus_if.d0, bus_if.min_pm}, '0);
      exp_q.delete();
      due_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);
      send(5, 15, 1, 3, 1'b1);
      idle(2);

      for (int i = 0; i < 400; i++)
         send(pick_pm(), pick_pm(), pick_pm(), pick_pm(), 1'($urandom_range(0, 3) != 0));
      idle(3);

      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: actual %0d results outstanding, required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
